pool_matrix_loader: RTL

- Upstream feeder for the pooling stage: accepts a row-major stream of 5-bit pixels over a valid/ready handshake and assembles one Row_Limit x Row_Limit frame into the bit-plane-packed matrix bus the pool stage consumes.
- Presents a completed frame as stable data with out_valid, holds it until the consumer acknowledges it, then reloads.
- Detects frame-length mismatches against in_last and discards the bad frame.

---
 rtl/fuzzy_matrix_pkg.sv | 14 +
 rtl/pool_matrix_loader_if.sv | 24 ++
 rtl/pool_matrix_loader_raster_counter.sv | 34 +++
 rtl/pool_matrix_loader.sv | 80 ++++++++
 4 files changed

// File: rtl/fuzzy_matrix_pkg.sv
// rtl/fuzzy_matrix_pkg.sv - shared widths, loader states and bit-plane index helper
package fuzzy_matrix_pkg;

   localparam int PIX_W             = 5;
   localparam int ROW_LIMIT_DEFAULT = 10;

   typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} loader_state_t;

   // Plane-major packing: all bit-k values of the frame are contiguous, raster order inside a plane.
   function automatic int plane_bit_index(int k, int r, int c, int rowLimit);
      return k * rowLimit * rowLimit + r * rowLimit + c;
   endfunction

endpackage

// File: rtl/pool_matrix_loader_if.sv
// rtl/pool_matrix_loader_if.sv - pixel stream in, packed frame out, with error pulse
interface pool_matrix_loader_if #(
   parameter int Row_Limit = fuzzy_matrix_pkg::ROW_LIMIT_DEFAULT,
   parameter int PIX_W     = fuzzy_matrix_pkg::PIX_W
);
   logic                               in_valid;
   logic [PIX_W-1:0]                   in_data;
   logic                               in_last;
   logic                               in_ready;
   logic [PIX_W*Row_Limit*Row_Limit-1:0] out_matrix;
   logic                               out_valid;
   logic                               out_ack;
   logic                               frame_err;

   modport master (
      output in_valid, in_data, in_last, out_ack,
      input  in_ready, out_matrix, out_valid, frame_err
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ack,
      output in_ready, out_matrix, out_valid, frame_err
   );
endinterface

// File: rtl/pool_matrix_loader_raster_counter.sv
// rtl/pool_matrix_loader_raster_counter.sv - row/col raster position, col fastest, wraps at Limit
module raster_counter #(
   parameter int Limit = 10,
   parameter int CntW  = $clog2(Limit)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   input  logic            advance,
   output logic [CntW-1:0] row,
   output logic [CntW-1:0] col,
   output logic            atEnd
);
   localparam logic [CntW-1:0] LastIdx = CntW'(Limit - 1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row <= '0;
         col <= '0;
      end else if (clear) begin
         row <= '0;
         col <= '0;
      end else if (advance) begin
         if (col == LastIdx) begin
            col <= '0;
            row <= (row == LastIdx) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign atEnd = (row == LastIdx) && (col == LastIdx);
endmodule

// File: rtl/pool_matrix_loader.sv
// rtl/pool_matrix_loader.sv - assembles one Row_Limit x Row_Limit pixel frame into bit planes,
// holds it until acknowledged, and drops frames whose length disagrees with in_last.
module pool_matrix_loader #(
   parameter int Row_Limit = fuzzy_matrix_pkg::ROW_LIMIT_DEFAULT,
   parameter int PIX_W     = fuzzy_matrix_pkg::PIX_W
) (
   input logic                clk,
   input logic                rst,
   pool_matrix_loader_if.slave bus
);
   import fuzzy_matrix_pkg::*;

   localparam int MatW    = PIX_W * Row_Limit * Row_Limit;
   localparam int IdxW    = $clog2(MatW);
   localparam int CntW    = $clog2(Row_Limit);
   localparam int PixIdxW = $clog2(PIX_W);

   localparam logic [0:0] StLoad = LOAD;
   localparam logic [0:0] StHold = HOLD;

   logic [0:0]      state;
   logic            started;
   logic [MatW-1:0] matrixReg;
   logic            frameErrReg;
   logic [CntW-1:0] row;
   logic [CntW-1:0] col;
   logic            atEnd;
   logic            accept;
   logic            frameEnd;

   assign accept   = bus.in_valid && bus.in_ready;
   // Either a last marker or the final raster position closes the frame, good or bad.
   assign frameEnd = accept && (atEnd || bus.in_last);

   raster_counter #(.Limit(Row_Limit), .CntW(CntW)) rasterCnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (frameEnd),
      .advance(accept),
      .row    (row),
      .col    (col),
      .atEnd  (atEnd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= StLoad;
         started     <= 1'b0;
         matrixReg   <= '0;
         frameErrReg <= 1'b0;
      end else begin
         started     <= 1'b1;
         frameErrReg <= 1'b0;
         case (state)
            StLoad: begin
               if (accept) begin
                  for (int k = 0; k < PIX_W; k++) begin
                     matrixReg[IdxW'(plane_bit_index(k, int'(row), int'(col), Row_Limit))] <=
                        bus.in_data[PixIdxW'(k)];
                  end
                  if (frameEnd) begin
                     if (atEnd && bus.in_last) state <= StHold;
                     else                      frameErrReg <= 1'b1;
                  end
               end
            end
            StHold: begin
               if (bus.out_ack) state <= StLoad;
            end
            default: state <= StLoad;
         endcase
      end
   end

   // started keeps in_ready low until the first edge after reset release.
   assign bus.in_ready   = started && (state == StLoad);
   assign bus.out_valid  = (state == StHold);
   assign bus.out_matrix = matrixReg;
   assign bus.frame_err  = frameErrReg;
endmodule
